// File: rtl/pk_decode_sequencer.sv
// Kyber768 public-key load/decode sequencer: gathers the key word stream into a pk register,
// exposes rho and serialises the 768 t coefficients with an on-the-fly modulus check.
module pk_decode_sequencer #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned PK_W   = 256 + 3 * 12 * 256,
    parameter int unsigned NWORDS = PK_W / WORD_W,
    parameter int unsigned Q      = 3329
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [255:0]      rho,
    output logic              rho_valid,
    output logic [11:0]       coef_data,
    output logic [1:0]        coef_poly,
    output logic [7:0]        coef_idx,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic              coef_last,
    output logic              range_err,
    output logic              done
);

    localparam int unsigned CW      = 12;
    localparam int unsigned NCOEF   = 768;
    localparam int unsigned N_W     = 10;
    localparam int unsigned CNT_W   = $clog2(NWORDS);
    localparam int unsigned PKIDX_W = $clog2(PK_W);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_EMIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PK_W-1:0]  pk_q, pk_d;
    logic [N_W-1:0]   n_q, n_d;
    logic [CW-1:0]    coef_data_q, coef_data_d;
    logic             in_ready_q, in_ready_d;
    logic             rho_valid_q, rho_valid_d;
    logic             coef_valid_q, coef_valid_d;
    logic             coef_last_q, coef_last_d;
    logic             range_err_q, range_err_d;
    logic             done_q, done_d;

    logic               accept, hs, load_coef;
    logic [PKIDX_W-1:0] wsel, csel;

    // Next-state and output logic; clr overrides everything, including a pending word or handshake.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pk_d         = pk_q;
        n_d          = n_q;
        coef_data_d  = coef_data_q;
        in_ready_d   = in_ready_q;
        rho_valid_d  = rho_valid_q;
        coef_valid_d = coef_valid_q;
        coef_last_d  = coef_last_q;
        range_err_d  = range_err_q;
        done_d       = 1'b0;
        load_coef    = 1'b0;
        accept       = in_valid && in_ready_q && (state_q == S_LOAD);
        hs           = coef_valid_q && coef_ready;
        wsel         = PKIDX_W'(WORD_W * cnt_q);
        csel         = '0;

        if (clr) begin
            state_d      = S_LOAD;
            cnt_d        = '0;
            n_d          = '0;
            in_ready_d   = 1'b1;
            rho_valid_d  = 1'b0;
            coef_valid_d = 1'b0;
            coef_last_d  = 1'b0;
            range_err_d  = 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    in_ready_d = 1'b1;
                    if (accept) begin
                        pk_d[wsel +: WORD_W] = in_data;
                        if (cnt_q == '0) begin
                            rho_valid_d = 1'b0;
                            range_err_d = 1'b0;
                        end
                        if (cnt_q == CNT_W'(NWORDS - 1)) begin
                            cnt_d        = '0;
                            state_d      = S_EMIT;
                            in_ready_d   = 1'b0;
                            rho_valid_d  = 1'b1;
                            coef_valid_d = 1'b1;
                            coef_last_d  = 1'b0;
                            n_d          = '0;
                            load_coef    = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    in_ready_d = 1'b0;
                    if (hs) begin
                        if (coef_last_q) begin
                            state_d      = S_DONE;
                            coef_valid_d = 1'b0;
                            coef_last_d  = 1'b0;
                            done_d       = 1'b1;
                            n_d          = '0;
                        end else begin
                            n_d         = n_q + 1'b1;
                            coef_last_d = (n_d == N_W'(NCOEF - 1));
                            load_coef   = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_d    = S_LOAD;
                    in_ready_d = 1'b1;
                end
                default: begin
                    state_d = S_LOAD;
                end
            endcase
        end

        // Coefficients live in the low bits, so the first one is already stored when the last word lands.
        if (load_coef) begin
            csel        = PKIDX_W'(CW * n_d);
            coef_data_d = pk_q[csel +: CW];
            if (coef_data_d >= CW'(Q)) begin
                range_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_LOAD;
            cnt_q        <= '0;
            pk_q         <= '0;
            n_q          <= '0;
            coef_data_q  <= '0;
            in_ready_q   <= 1'b0;
            rho_valid_q  <= 1'b0;
            coef_valid_q <= 1'b0;
            coef_last_q  <= 1'b0;
            range_err_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pk_q         <= pk_d;
            n_q          <= n_d;
            coef_data_q  <= coef_data_d;
            in_ready_q   <= in_ready_d;
            rho_valid_q  <= rho_valid_d;
            coef_valid_q <= coef_valid_d;
            coef_last_q  <= coef_last_d;
            range_err_q  <= range_err_d;
            done_q       <= done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign rho        = pk_q[PK_W-1 -: 256];
    assign rho_valid  = rho_valid_q;
    assign coef_data  = coef_data_q;
    assign coef_poly  = n_q[9:8];
    assign coef_idx   = n_q[7:0];
    assign coef_valid = coef_valid_q;
    assign coef_last  = coef_last_q;
    assign range_err  = range_err_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pk_decode_sequencer.sv
// Directed bench for pk_decode_sequencer: builds keys from coefficient patterns, streams them
// and compares every output each cycle against a small cycle model.
module tb_pk_decode_sequencer;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned PK_W   = 9472;
    localparam int unsigned NWORDS = 296;
    localparam int unsigned NCOEF  = 768;
    localparam int unsigned Q      = 3329;

    logic              clk;
    logic              rst;
    logic              clr;
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [255:0]      rho;
    logic              rho_valid;
    logic [11:0]       coef_data;
    logic [1:0]        coef_poly;
    logic [7:0]        coef_idx;
    logic              coef_valid;
    logic              coef_ready;
    logic              coef_last;
    logic              range_err;
    logic              done;

    pk_decode_sequencer #(
        .WORD_W(WORD_W), .PK_W(PK_W), .NWORDS(NWORDS), .Q(Q)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .rho(rho), .rho_valid(rho_valid),
        .coef_data(coef_data), .coef_poly(coef_poly), .coef_idx(coef_idx),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_last(coef_last),
        .range_err(range_err), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int done_cyc = 0;
    int d1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [PK_W-1:0] pk_m;
    logic [255:0]    m_rho;
    logic            m_rv;
    logic            m_rerr;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // pat 0: every coefficient = base; pat 1: ramp (13*i+7) mod q. sp_n >= 0 overrides one coefficient.
    task automatic make_key(input int pat, input int base, input int sp_n, input int sp_val,
                            input logic [255:0] r);
        int c;
        for (int i = 0; i < NCOEF; i++) begin
            c = (pat == 0) ? base : (i * 13 + 7) % 3329;
            if (i == sp_n) c = sp_val;
            pk_m[12*i +: 12] = 12'(c);
        end
        pk_m[PK_W-1 -: 256] = r;
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_in_ready"}, in_ready, 0);
        check_val({tag, "_rho_valid"}, rho_valid, 0);
        check_val({tag, "_rho"}, rho, 0);
        check_val({tag, "_coef_valid"}, coef_valid, 0);
        check_val({tag, "_coef_last"}, coef_last, 0);
        check_val({tag, "_range_err"}, range_err, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_coef_poly"}, coef_poly, 0);
        check_val({tag, "_coef_idx"}, coef_idx, 0);
        check_val({tag, "_coef_data"}, coef_data, 0);
    endtask

    // Streams pk_m and checks every output each cycle; returns at done, or when coefficient abort_n is shown.
    task automatic run_key(input bit gaps, input bit stall, input int abort_n);
        int w = 0;
        int n = 0;
        bit emit = 1'b0;
        bit tog = 1'b0;
        bit ev, iv, cr;
        logic [11:0] c;
        for (int guard = 0; guard < 4000; guard++) begin
            @(negedge clk);
            ev = emit && (n < NCOEF);
            c  = '0;
            if (ev) begin
                c = pk_m[12*n +: 12];
                if (c >= 12'(Q)) m_rerr = 1'b1;
            end
            check_val("in_ready", in_ready, (w < NWORDS));
            check_val("rho_valid", rho_valid, m_rv);
            if (m_rv) check_val("rho", rho, m_rho);
            check_val("range_err", range_err, m_rerr);
            check_val("coef_valid", coef_valid, ev);
            check_val("done", done, (emit && n == NCOEF));
            if (ev) begin
                check_val("coef_poly", coef_poly, n / 256);
                check_val("coef_idx", coef_idx, n % 256);
                check_val("coef_data", coef_data, c);
                check_val("coef_last", coef_last, (n == NCOEF - 1));
                if (n == abort_n) return;
            end
            if (emit && n == NCOEF) begin
                done_cyc = cyc;
                return;
            end
            iv = (w < NWORDS) && (!gaps || $urandom_range(0, 2) != 0);
            in_valid = iv;
            in_data  = (w < NWORDS) ? pk_m[WORD_W*w +: WORD_W] : '0;
            tog = ~tog;
            cr  = stall ? tog : 1'b1;
            coef_ready = cr;
            if (iv) begin
                if (w == 0) begin
                    m_rv   = 1'b0;
                    m_rerr = 1'b0;
                end
                w++;
                if (w == NWORDS) begin
                    emit  = 1'b1;
                    m_rv  = 1'b1;
                    m_rho = pk_m[PK_W-1 -: 256];
                end
            end
            if (ev && cr) n++;
        end
        check_val("timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; coef_ready = 1'b0;
        pk_m = '0; m_rho = '0; m_rv = 1'b0; m_rerr = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        check_val("in_ready_after_reset", in_ready, 1);

        // All-ones coefficients, A5 rho, unthrottled.
        make_key(0, 1, -1, 0, {32{8'hA5}});
        run_key(1'b0, 1'b0, -1);
        d1 = done_cyc;

        // Back-to-back ramp key: rho of the first key must survive until word 0 is taken.
        make_key(1, 0, -1, 0, {8{32'h3C5A_0F96}});
        run_key(1'b0, 1'b0, -1);
        check_val("key_period", done_cyc - d1, 1065);

        // Same A5 key with input gaps and coef_ready toggling.
        make_key(0, 1, -1, 0, {32{8'hA5}});
        run_key(1'b1, 1'b1, -1);

        // Modulus boundary: 3328 everywhere, 3329 at poly 1 coef 17.
        make_key(0, 12'hD00, 256 + 17, 12'hD01, {32{8'h0F}});
        run_key(1'b0, 1'b0, -1);

        // Abort a partial load with clr on word 150, then a fresh key.
        make_key(1, 0, -1, 0, {32{8'hFF}});
        for (int w = 0; w < 150; w++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = pk_m[WORD_W*w +: WORD_W];
            coef_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = pk_m[WORD_W*150 +: WORD_W];
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        in_valid = 1'b0;
        m_rv = 1'b0;
        m_rerr = 1'b0;
        check_val("clr_in_ready", in_ready, 1);
        check_val("clr_rho_valid", rho_valid, 0);
        check_val("clr_range_err", range_err, 0);
        check_val("clr_coef_valid", coef_valid, 0);
        check_val("clr_done", done, 0);
        make_key(0, 12'h5A5, -1, 0, {16{16'h1234}});
        run_key(1'b0, 1'b0, -1);

        // Reset while coefficient (0,100) is on the bus, then a full key.
        make_key(0, 1, -1, 0, {32{8'hA5}});
        run_key(1'b0, 1'b0, 100);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        m_rv = 1'b0;
        m_rerr = 1'b0;
        m_rho = '0;
        make_key(1, 0, -1, 0, {8{32'h3C5A_0F96}});
        run_key(1'b0, 1'b0, -1);

        @(negedge clk);
        check_val("final_done_low", done, 0);
        check_val("final_in_ready", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pk_decode_sequencer.md
Name: pk_decode_sequencer

Overview:
- Accepts a Kyber768 public key as a stream of 32-bit words and assembles it into the full pk vector.
- Drives the combinational public-key decoder: rho is presented as a held 256-bit bus, and the t polynomials are serialised as a coefficient stream.
- Sits between the host/DMA input interface and the encapsulation datapath (matrix-A generation consumes rho; the t·r multiply consumes coefficients).
- Performs the FIPS 203 modulus check (each coefficient < q) on the fly.

Parameters:
- WORD_W, 32, input word width; must divide PK_W.
- PK_W, `KYBER_N + `KYBER_K*`KYBER_R_WIDTH*`KYBER_N (9472), public-key bit width.
- NWORDS, PK_W/WORD_W (296), words per key.
- Q, `KYBER_Q (3329), modulus used for the range check.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous abort; returns to S_LOAD and discards the partial key.
- in_data  in  WORD_W  key word; stream bit b of word w maps to pk bit WORD_W*w+b.
- in_valid  in  1  word valid.
- in_ready  out  1  sequencer can accept a word.
- rho  out  256  decoded rho; stable while rho_valid.
- rho_valid  out  1  rho holds the current key.
- coef_data  out  12  t coefficient.
- coef_poly  out  2  polynomial index 0..2.
- coef_idx  out  8  coefficient index 0..255.
- coef_valid  out  1  coefficient valid.
- coef_ready  in  1  downstream accepts the coefficient.
- coef_last  out  1  marks the final coefficient (poly 2, idx 255).
- range_err  out  1  sticky: some coefficient of the current key is >= Q.
- done  out  1  one-cycle pulse after the last coefficient handshake.

Behaviour:
- Field mapping:
  - Polynomial i coefficient j = pk bits [12*(256*i+j)+11 : 12*(256*i+j)].
  - rho = pk[PK_W-1 : PK_W-256].
  - Decoding goes through the existing decoder on the internal pk register.
- Reset (rst high, async): state=S_LOAD, word count=0, pk register=0, in_ready=0 during reset then 1, rho_valid=0, coef_valid=0, coef_last=0, range_err=0, done=0, coef_poly=0, coef_idx=0, coef_data=0.
- S_LOAD:
  - in_ready=1.
  - Word accepted when in_valid&in_ready; it is written to slice [WORD_W*cnt +: WORD_W] and cnt increments.
  - Accepting word 0 clears rho_valid and range_err (previous key retired).
  - On acceptance of word NWORDS-1: cnt wraps to 0 and next state is S_EMIT.
- S_EMIT:
  - in_ready=0; rho_valid=1 from the first S_EMIT cycle.
  - coef_valid=1 starting the cycle after the last word is accepted (latency 1).
  - Outputs are registered. They hold while coef_valid&!coef_ready (AXI-style: no retraction, no change).
  - On handshake, idx increments. idx 255 wraps to 0 and poly increments.
  - On the handshake where coef_last=1, next state is S_DONE.
  - range_err sets in the cycle a coefficient >= Q is presented (valid), not at handshake.
- S_DONE:
  - Single cycle: done=1, coef_valid=0.
  - rho_valid and range_err held.
  - Next state is S_LOAD, with in_ready=1 the following cycle.
- Back-to-back keys: rho_valid stays 1 through S_LOAD until the next key's word 0 is accepted.
- clr:
  - clr=1 in any state: next cycle state=S_LOAD, cnt=0, coef_valid=0, rho_valid=0, range_err=0, done=0, indices=0.
  - clr beats a simultaneous in_valid (word dropped, not written) and a simultaneous coef handshake (treated as not taken).
  - pk register contents are don't-care after clr.
- in_valid in S_EMIT/S_DONE is ignored (in_ready=0); the word is not consumed.
- Reset mid-operation: immediate return to reset values; no done pulse.
- Throughput: 1 word/cycle in, 1 coef/cycle out.
  - Minimum key period: NWORDS + 768 + 1 cycles (296 + 768 + 1 = 1065).

Test Plan:
- Stream a key with all t coefficients = 12'h001 and rho = 256'hA5A5…, in_valid always 1, coef_ready always 1 -> rho_valid rises 1 cycle after word 295 is accepted. Expect 768 coefficients of 1 in order (0,0)…(2,255), coef_last only on (2,255), done 1 cycle later, range_err=0.
- Same key with coef_ready toggling 1,0,1,0 and random in_valid gaps -> identical coefficient sequence, no duplicates or skips, outputs stable while stalled, done exactly once.
- Key with poly 1 coef 17 = 12'hD01 (3329) and all others 12'hD00 (3328) -> range_err=0 through (1,16), then 1 from the cycle (1,17) is valid until word 0 of the next key.
- Assert clr on the cycle word 150 is offered with in_valid=1 -> word not written, in_ready=1 next cycle. Then stream a full fresh key -> correct rho/coefficients and no residue from the aborted key.
- Assert rst at coefficient (0,100) in S_EMIT -> all outputs immediately take reset values. After release, the next full key decodes correctly.
- Two keys back-to-back -> the first key's rho stays valid through S_LOAD until the second key's word 0 is accepted. The second key's rho then appears, and two done pulses are 1065 cycles apart with unthrottled streams.
